// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall detection and forwarding selects for a
// five-stage pipeline, with shadow copies of the EX and M destination fields.
module hazard_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d_rs,
  input  logic [3:0] d_rt,
  input  logic       d_rs_used,
  input  logic       d_rt_used,
  input  logic [3:0] d_dst,
  input  logic       d_writes_reg,
  input  logic       d_is_load,
  input  logic       d_is_store,
  input  logic       flush,
  input  logic       freeze,
  output logic       stall,
  output logic [1:0] ex_ex_forwarding,
  output logic [1:0] ex_mem_forwarding,
  output logic       mem_mem_forwarding
);

  logic [3:0] ex_dst_r;
  logic       ex_wr_r;
  logic       ex_load_r;
  logic       ex_mm_r;
  logic [3:0] m_dst_r;
  logic       m_wr_r;

  logic       ex_rs_s, ex_rt_s, m_rs_s, m_rt_s;
  logic       load_rs_s, load_rt_s;
  logic       bubble_s, mm_pend_s;
  logic [1:0] fwd_ex_s, fwd_mem_s;

  // R0 is hardwired to zero, so it never creates a dependency.
  function automatic logic hits(input logic [3:0] r, input logic used,
                                input logic [3:0] dst, input logic wr);
    return wr && used && (dst == r) && (r != 4'd0);
  endfunction

  // Operand compares, load-use detection and next forwarding selects.
  always_comb begin
    ex_rs_s   = hits(d_rs, d_rs_used, ex_dst_r, ex_wr_r);
    ex_rt_s   = hits(d_rt, d_rt_used, ex_dst_r, ex_wr_r);
    m_rs_s    = hits(d_rs, d_rs_used, m_dst_r, m_wr_r);
    m_rt_s    = hits(d_rt, d_rt_used, m_dst_r, m_wr_r);
    load_rs_s = ex_rs_s && ex_load_r;
    load_rt_s = ex_rt_s && ex_load_r;
    // Store data from a load in EX can be picked up in M instead of stalling.
    mm_pend_s = d_is_store && load_rt_s && !load_rs_s;
    stall     = (load_rs_s || (load_rt_s && !d_is_store)) && !flush;
    bubble_s  = load_rs_s || (load_rt_s && !d_is_store) || flush;
    fwd_ex_s  = {ex_rt_s, ex_rs_s};
    fwd_mem_s = {m_rt_s && !ex_rt_s, m_rs_s && !ex_rs_s};
  end

  // Shadow pipeline entries and registered forwarding outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_dst_r           <= 4'd0;
      ex_wr_r            <= 1'b0;
      ex_load_r          <= 1'b0;
      ex_mm_r            <= 1'b0;
      m_dst_r            <= 4'd0;
      m_wr_r             <= 1'b0;
      ex_ex_forwarding   <= 2'b00;
      ex_mem_forwarding  <= 2'b00;
      mem_mem_forwarding <= 1'b0;
    end else if (!freeze) begin
      m_dst_r            <= ex_dst_r;
      m_wr_r             <= ex_wr_r;
      mem_mem_forwarding <= ex_mm_r;
      if (bubble_s) begin
        ex_dst_r          <= 4'd0;
        ex_wr_r           <= 1'b0;
        ex_load_r         <= 1'b0;
        ex_mm_r           <= 1'b0;
        ex_ex_forwarding  <= 2'b00;
        ex_mem_forwarding <= 2'b00;
      end else begin
        ex_dst_r          <= d_dst;
        ex_wr_r           <= d_writes_reg;
        ex_load_r         <= d_is_load;
        ex_mm_r           <= mm_pend_s;
        ex_ex_forwarding  <= fwd_ex_s;
        ex_mem_forwarding <= fwd_mem_s;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed vector table, an async reset
// sequence, and randomized traffic against an instruction-level model.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] d_rs, d_rt, d_dst;
  logic       d_rs_used, d_rt_used, d_writes_reg, d_is_load, d_is_store;
  logic       flush, freeze;
  logic       stall;
  logic [1:0] ex_ex_forwarding, ex_mem_forwarding;
  logic       mem_mem_forwarding;

  int checks = 0;
  int passes = 0;

  hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .d_rs(d_rs), .d_rt(d_rt),
    .d_rs_used(d_rs_used), .d_rt_used(d_rt_used), .d_dst(d_dst),
    .d_writes_reg(d_writes_reg), .d_is_load(d_is_load), .d_is_store(d_is_store),
    .flush(flush), .freeze(freeze), .stall(stall),
    .ex_ex_forwarding(ex_ex_forwarding), .ex_mem_forwarding(ex_mem_forwarding),
    .mem_mem_forwarding(mem_mem_forwarding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rs, rt, dst;
    logic       ru, tu, wr, ld, st, fl, fz;
    logic       e_stall;
    logic [1:0] e_ee, e_em;
    logic       e_mm;
  } vec_t;

  typedef struct {
    logic [3:0] dst;
    bit         wr, ld;
  } instr_t;

  function automatic vec_t v(int rs, int rt, int ru, int tu, int dst, int wr,
                             int ld, int st, int fl, int fz,
                             int es, int ee, int em, int mm);
    vec_t r;
    r.rs = 4'(rs); r.rt = 4'(rt); r.ru = 1'(ru); r.tu = 1'(tu);
    r.dst = 4'(dst); r.wr = 1'(wr); r.ld = 1'(ld); r.st = 1'(st);
    r.fl = 1'(fl); r.fz = 1'(fz);
    r.e_stall = 1'(es); r.e_ee = 2'(ee); r.e_em = 2'(em); r.e_mm = 1'(mm);
    return r;
  endfunction

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input vec_t t);
    d_rs = t.rs; d_rt = t.rt; d_rs_used = t.ru; d_rt_used = t.tu;
    d_dst = t.dst; d_writes_reg = t.wr; d_is_load = t.ld; d_is_store = t.st;
    flush = t.fl; freeze = t.fz;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(v(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Model: a producer supplies operand r if it writes a nonzero r that is read.
  function automatic bit reads(logic [3:0] r, bit used, instr_t p);
    return used && p.wr && p.dst == r && r != 4'd0;
  endfunction

  vec_t tbl[33];
  instr_t m_ex, m_m, cur;
  logic [1:0] m_ee, m_em;
  bit m_mm_ex, m_mm;
  bit haz, m_stall, r_rs, r_rt, mm_now;

  initial begin
    rst_n = 1'b0;
    drive(v(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    #12;
    chk("reset_stall", {1'b0, stall}, 2'b00);
    chk("reset_exex", ex_ex_forwarding, 2'b00);
    chk("reset_exmem", ex_mem_forwarding, 2'b00);
    chk("reset_mm", {1'b0, mem_mem_forwarding}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    //          rs rt ru tu dst wr ld st fl fz | stall ee em mm
    tbl[0]  = v(1, 2, 1, 1, 3, 1, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[1]  = v(3, 5, 1, 1, 4, 1, 0, 0, 0, 0,  0, 1, 0, 0);
    tbl[2]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[3]  = v(1, 2, 1, 1, 3, 1, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[4]  = v(1, 2, 1, 1, 6, 1, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[5]  = v(1, 3, 1, 1, 7, 1, 0, 0, 0, 0,  0, 0, 2, 0);
    tbl[6]  = v(1, 0, 1, 0, 2, 1, 1, 0, 0, 0,  0, 0, 0, 0);
    tbl[7]  = v(2, 1, 1, 1, 6, 1, 0, 0, 0, 0,  1, 0, 0, 0);
    tbl[8]  = v(2, 1, 1, 1, 6, 1, 0, 0, 0, 0,  0, 0, 1, 0);
    tbl[9]  = v(1, 0, 1, 0, 2, 1, 1, 0, 0, 0,  0, 0, 0, 0);
    tbl[10] = v(7, 2, 1, 1, 0, 0, 0, 1, 0, 0,  0, 2, 0, 0);
    tbl[11] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
    tbl[12] = v(1, 0, 1, 0, 2, 1, 1, 0, 0, 0,  0, 0, 0, 0);
    tbl[13] = v(2, 5, 1, 1, 0, 0, 0, 1, 0, 0,  1, 0, 0, 0);
    tbl[14] = v(2, 5, 1, 1, 0, 0, 0, 1, 0, 0,  0, 0, 1, 0);
    tbl[15] = v(1, 1, 1, 1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[16] = v(0, 0, 1, 1, 5, 1, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[17] = v(0, 0, 1, 1, 6, 1, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[18] = v(1, 1, 1, 1, 3, 1, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[19] = v(3, 0, 1, 0, 2, 1, 1, 0, 0, 0,  0, 1, 0, 0);
    tbl[20] = v(2, 1, 1, 1, 6, 1, 0, 0, 0, 1,  1, 1, 0, 0);
    tbl[21] = v(2, 1, 1, 1, 6, 1, 0, 0, 0, 1,  1, 1, 0, 0);
    tbl[22] = v(2, 1, 1, 1, 6, 1, 0, 0, 0, 1,  1, 1, 0, 0);
    tbl[23] = v(2, 1, 1, 1, 6, 1, 0, 0, 0, 0,  1, 0, 0, 0);
    tbl[24] = v(2, 1, 1, 1, 6, 1, 0, 0, 0, 0,  0, 0, 1, 0);
    tbl[25] = v(1, 0, 1, 0, 2, 1, 1, 0, 0, 0,  0, 0, 0, 0);
    tbl[26] = v(2, 1, 1, 1, 6, 1, 0, 0, 1, 0,  0, 0, 0, 0);
    tbl[27] = v(2, 1, 1, 1, 6, 1, 0, 0, 0, 0,  0, 0, 1, 0);
    tbl[28] = v(1, 1, 1, 1, 3, 1, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[29] = v(1, 1, 1, 1, 3, 1, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[30] = v(3, 3, 1, 1, 4, 1, 0, 0, 0, 0,  0, 3, 0, 0);
    tbl[31] = v(3, 3, 1, 1, 5, 1, 0, 0, 0, 0,  0, 0, 3, 0);
    tbl[32] = v(3, 3, 1, 1, 6, 1, 0, 0, 0, 0,  0, 0, 0, 0);

    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("row%0d_stall", i), {1'b0, stall}, {1'b0, tbl[i].e_stall});
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_exex", i), ex_ex_forwarding, tbl[i].e_ee);
      chk($sformatf("row%0d_exmem", i), ex_mem_forwarding, tbl[i].e_em);
      chk($sformatf("row%0d_mm", i), {1'b0, mem_mem_forwarding}, {1'b0, tbl[i].e_mm});
    end

    // Async reset while a load-use stall and an EX forward are both active.
    do_reset();
    drive(v(1, 1, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(v(3, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(v(2, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("pre_rst_stall", {1'b0, stall}, 2'b01);
    chk("pre_rst_exex", ex_ex_forwarding, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("async_rst_stall", {1'b0, stall}, 2'b00);
    chk("async_rst_exex", ex_ex_forwarding, 2'b00);
    chk("async_rst_exmem", ex_mem_forwarding, 2'b00);
    chk("async_rst_mm", {1'b0, mem_mem_forwarding}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the instruction-level model.
    do_reset();
    m_ex = '{default: 0}; m_m = '{default: 0};
    m_ee = 2'b00; m_em = 2'b00; m_mm_ex = 1'b0; m_mm = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      d_rs = 4'($urandom_range(0, 3)); d_rt = 4'($urandom_range(0, 3));
      d_dst = 4'($urandom_range(0, 3));
      d_rs_used = 1'($urandom_range(0, 1)); d_rt_used = 1'($urandom_range(0, 1));
      d_is_load = ($urandom_range(0, 3) == 0);
      d_is_store = !d_is_load && ($urandom_range(0, 3) == 0);
      d_writes_reg = !d_is_store && ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 7) == 0);
      freeze = ($urandom_range(0, 7) == 0);
      r_rs = reads(d_rs, d_rs_used, m_ex);
      r_rt = reads(d_rt, d_rt_used, m_ex);
      haz = m_ex.ld && (r_rs || (r_rt && !d_is_store));
      m_stall = haz && !flush;
      mm_now = d_is_store && m_ex.ld && r_rt && !r_rs;
      #1;
      chk("rnd_stall", {1'b0, stall}, {1'b0, m_stall});
      if (!freeze) begin
        m_mm = m_mm_ex;
        if (haz || flush) begin
          m_m = m_ex;
          m_ex = '{default: 0};
          m_ee = 2'b00; m_em = 2'b00; m_mm_ex = 1'b0;
        end else begin
          m_ee = {r_rt, r_rs};
          m_em[0] = !r_rs && reads(d_rs, d_rs_used, m_m);
          m_em[1] = !r_rt && reads(d_rt, d_rt_used, m_m);
          m_mm_ex = mm_now;
          cur.dst = d_dst; cur.wr = d_writes_reg; cur.ld = d_is_load;
          m_m = m_ex;
          m_ex = cur;
        end
      end
      @(posedge clk);
      #1;
      chk("rnd_exex", ex_ex_forwarding, m_ee);
      chk("rnd_exmem", ex_mem_forwarding, m_em);
      chk("rnd_mm", {1'b0, mem_mem_forwarding}, {1'b0, m_mm});
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
